// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among pipeline, LSU late-return and MDU writebacks.
// One registered stage (grant at edge N -> rf_* valid after edge N); losers see ready low and hold.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REGW       = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [REGW-1:0] pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_ready,
    input  logic            lsu_valid,
    input  logic [REGW-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            mdu_valid,
    input  logic [REGW-1:0] mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [REGW-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            lsu_starved,
    output logic            mdu_starved
);

    localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

    logic [3:0]      r_lsu_cnt;
    logic [3:0]      r_mdu_cnt;
    logic [3:0]      w_lsu_cnt_nxt;
    logic [3:0]      w_mdu_cnt_nxt;
    logic            w_lsu_starved;
    logic            w_mdu_starved;
    logic            w_gnt_pipe;
    logic            w_gnt_lsu;
    logic            w_gnt_mdu;
    logic            w_gnt_any;
    logic [REGW-1:0] w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            r_rf_we;
    logic [REGW-1:0] r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;

    assign w_lsu_starved = (r_lsu_cnt == LP_SMAX);
    assign w_mdu_starved = (r_mdu_cnt == LP_SMAX);

    // Starved requesters jump the queue (lsu first); otherwise fixed pipe > lsu > mdu.
    always_comb begin
        w_gnt_pipe = 1'b0;
        w_gnt_lsu  = 1'b0;
        w_gnt_mdu  = 1'b0;
        if (rst_n) begin
            if (lsu_valid && w_lsu_starved)      w_gnt_lsu  = 1'b1;
            else if (mdu_valid && w_mdu_starved) w_gnt_mdu  = 1'b1;
            else if (pipe_valid)                 w_gnt_pipe = 1'b1;
            else if (lsu_valid)                  w_gnt_lsu  = 1'b1;
            else if (mdu_valid)                  w_gnt_mdu  = 1'b1;
        end
    end

    assign w_gnt_any = w_gnt_pipe | w_gnt_lsu | w_gnt_mdu;

    always_comb begin
        w_sel_rd   = pipe_rd;
        w_sel_data = pipe_data;
        if (w_gnt_lsu) begin
            w_sel_rd   = lsu_rd;
            w_sel_data = lsu_data;
        end else if (w_gnt_mdu) begin
            w_sel_rd   = mdu_rd;
            w_sel_data = mdu_data;
        end
    end

    // A saturated counter holds so a still-blocked starved mdu wins next cycle.
    always_comb begin
        w_lsu_cnt_nxt = '0;
        w_mdu_cnt_nxt = '0;
        if (lsu_valid && !w_gnt_lsu)
            w_lsu_cnt_nxt = w_lsu_starved ? r_lsu_cnt : r_lsu_cnt + 4'd1;
        if (mdu_valid && !w_gnt_mdu)
            w_mdu_cnt_nxt = w_mdu_starved ? r_mdu_cnt : r_mdu_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lsu_cnt  <= '0;
            r_mdu_cnt  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_lsu_cnt <= w_lsu_cnt_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
            r_rf_we   <= w_gnt_any && (w_sel_rd != '0);
            if (w_gnt_any) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    assign pipe_ready  = w_gnt_pipe;
    assign lsu_ready   = w_gnt_lsu;
    assign mdu_ready   = w_gnt_mdu;
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign lsu_starved = w_lsu_starved;
    assign mdu_starved = w_mdu_starved;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_wb_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid, lsu_valid, mdu_valid;
    logic [4:0]  pipe_rd, lsu_rd, mdu_rd;
    logic [31:0] pipe_data, lsu_data, mdu_data;
    logic        pipe_ready, lsu_ready, mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lsu_starved, mdu_starved;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_lc = 0;
    int          m_mc = 0;
    bit          m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(32), .REGW(5), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .lsu_starved(lsu_starved), .mdu_starved(mdu_starved)
    );

    // Winner by the arbitration rules: 0=pipe 1=lsu 2=mdu -1=none
    function automatic int ref_pick(bit rn, bit pv, bit lv, bit mv, int lc, int mc);
        if (!rn)            return -1;
        if (lv && lc == SM) return 1;
        if (mv && mc == SM) return 2;
        if (pv)             return 0;
        if (lv)             return 1;
        if (mv)             return 2;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(int g);
        case (g)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int cur_pick();
        return ref_pick(rst_n, pipe_valid, lsu_valid, mdu_valid, m_lc, m_mc);
    endfunction

    // Advance the model over one clock edge using the currently driven inputs, then step the clock.
    task automatic clock_edge();
        int g;
        g = cur_pick();
        if (!rst_n) begin
            m_lc = 0; m_mc = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_lc = (lsu_valid && g != 1) ? ((m_lc + 1 > SM) ? SM : m_lc + 1) : 0;
            m_mc = (mdu_valid && g != 2) ? ((m_mc + 1 > SM) ? SM : m_mc + 1) : 0;
            m_we = 1'b0;
            if (g == 0) begin m_we = (pipe_rd != 0); m_waddr = pipe_rd; m_wdata = pipe_data; end
            if (g == 1) begin m_we = (lsu_rd != 0);  m_waddr = lsu_rd;  m_wdata = lsu_data;  end
            if (g == 2) begin m_we = (mdu_rd != 0);  m_waddr = mdu_rd;  m_wdata = mdu_data;  end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; lsu_valid = 0; mdu_valid = 0;
        pipe_rd = 0; lsu_rd = 0; mdu_rd = 0;
        pipe_data = 0; lsu_data = 0; mdu_data = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        pipe_valid = 1; lsu_valid = 1; mdu_valid = 1;
        pipe_rd = 1; lsu_rd = 2; mdu_rd = 3;
        pipe_data = 32'h11; lsu_data = 32'h22; mdu_data = 32'h33;
        #1;
        checks++;
        if ({pipe_ready, lsu_ready, mdu_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready got %b want 000", {pipe_ready, lsu_ready, mdu_ready});
        end
        clock_edge();
        clock_edge();
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++;
        if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
        checks++;
        if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
        checks++;
        if ({lsu_starved, mdu_starved} !== 2'b00) begin
            errors++; $display("FAIL reset_starved got %b want 00", {lsu_starved, mdu_starved});
        end
        idle_inputs();
        rst_n = 1;
        clock_edge();
    endtask

    task automatic test_single_pipe();
        pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({pipe_ready, lsu_ready, mdu_ready} !== 3'b100) begin
            errors++; $display("FAIL single_ready got %b want 100", {pipe_ready, lsu_ready, mdu_ready});
        end
        clock_edge();
        pipe_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write got we=%b x%0d=%h want we=1 x5=deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        clock_edge();
    endtask

    task automatic test_priority();
        logic [2:0] exp_rdy [3];
        exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b001;
        pipe_valid = 1; lsu_valid = 1; mdu_valid = 1;
        pipe_rd = 1; lsu_rd = 2; mdu_rd = 3;
        pipe_data = 32'hA1; lsu_data = 32'hA2; mdu_data = 32'hA3;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c < 3) begin
                checks++;
                if ({pipe_ready, lsu_ready, mdu_ready} !== exp_rdy[c]) begin
                    errors++;
                    $display("FAIL prio_ready c%0d got %b want %b", c, {pipe_ready, lsu_ready, mdu_ready}, exp_rdy[c]);
                end
            end
            if (c > 0) begin
                checks++;
                if (rf_we !== 1'b1 || rf_waddr !== 5'(c) || rf_wdata !== 32'hA0 + 32'(c)) begin
                    errors++;
                    $display("FAIL prio_write c%0d got we=%b x%0d=%h want x%0d=%h",
                             c, rf_we, rf_waddr, rf_wdata, c, 32'hA0 + 32'(c));
                end
            end
            clock_edge();
            if (c == 0) pipe_valid = 0;
            if (c == 1) lsu_valid = 0;
            if (c == 2) mdu_valid = 0;
        end
    endtask

    task automatic test_starvation();
        bit lsu_done = 0;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            pipe_valid = 1; pipe_rd = 5'(10 + c); pipe_data = 32'(c);
            lsu_valid = !lsu_done;
            #1;
            checks++;
            if (lsu_ready !== (c == 4) || pipe_ready !== (c != 4)) begin
                errors++;
                $display("FAIL starve_ready c%0d got pipe=%b lsu=%b want pipe=%b lsu=%b",
                         c, pipe_ready, lsu_ready, c != 4, c == 4);
            end
            checks++;
            if (lsu_starved !== (c == 4)) begin
                errors++; $display("FAIL starve_flag c%0d got %b want %b", c, lsu_starved, c == 4);
            end
            if (c == 5) begin
                checks++;
                if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL starve_write got we=%b x%0d=%h want x7=12345678", rf_we, rf_waddr, rf_wdata);
                end
            end
            clock_edge();
            if (c == 4) lsu_done = 1;
        end
        idle_inputs();
        clock_edge();
    endtask

    task automatic test_dual_starvation();
        logic [2:0] exp_rdy [8];
        bit ld = 0, md = 0;
        for (int c = 0; c < 8; c++) exp_rdy[c] = 3'b100;
        exp_rdy[4] = 3'b010; exp_rdy[5] = 3'b001;
        lsu_rd = 8; lsu_data = 32'h8888; mdu_rd = 9; mdu_data = 32'h9999;
        for (int c = 0; c < 8; c++) begin
            pipe_valid = 1; pipe_rd = 5'(20 + c); pipe_data = 32'(100 + c);
            lsu_valid = !ld; mdu_valid = !md;
            #1;
            checks++;
            if ({pipe_ready, lsu_ready, mdu_ready} !== exp_rdy[c]) begin
                errors++;
                $display("FAIL dual_ready c%0d got %b want %b", c, {pipe_ready, lsu_ready, mdu_ready}, exp_rdy[c]);
            end
            if (c == 5) begin
                checks++;
                if (mdu_starved !== 1'b1) begin errors++; $display("FAIL dual_mdu_flag got %b want 1", mdu_starved); end
            end
            if (c == 6) begin
                checks++;
                if (rf_waddr !== 5'd9 || rf_wdata !== 32'h9999) begin
                    errors++; $display("FAIL dual_write got x%0d=%h want x9=9999", rf_waddr, rf_wdata);
                end
            end
            clock_edge();
            if (c == 4) ld = 1;
            if (c == 5) md = 1;
        end
        idle_inputs();
        clock_edge();
    endtask

    task automatic test_rd_zero();
        mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if ({pipe_ready, lsu_ready, mdu_ready} !== 3'b001) begin
            errors++; $display("FAIL rd0_ready got %b want 001", {pipe_ready, lsu_ready, mdu_ready});
        end
        clock_edge();
        mdu_valid = 0;
        checks++;
        if (rf_we !== 1'b0 || rf_wdata !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL rd0_write got we=%b data=%h want we=0 data=ffffffff", rf_we, rf_wdata);
        end
        clock_edge();
    endtask

    task automatic test_midop_reset();
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h55;
        for (int c = 0; c < 4; c++) begin
            pipe_valid = 1; pipe_rd = 5'(1 + c); pipe_data = 32'(c);
            clock_edge();
        end
        rst_n = 0;
        #1;
        checks++;
        if ({pipe_ready, lsu_ready, mdu_ready} !== 3'b000) begin
            errors++; $display("FAIL midrst_ready got %b want 000", {pipe_ready, lsu_ready, mdu_ready});
        end
        clock_edge();
        rst_n = 1;
        checks++;
        if (rf_we !== 1'b0 || lsu_starved !== 1'b0) begin
            errors++; $display("FAIL midrst_state got we=%b starved=%b want 0 0", rf_we, lsu_starved);
        end
        // A freshly cleared counter needs the full blocked run again before lsu wins.
        for (int c = 0; c < 5; c++) begin
            pipe_rd = 5'(1 + c);
            #1;
            checks++;
            if (lsu_ready !== (c == 4)) begin
                errors++; $display("FAIL midrst_recount c%0d got lsu_ready=%b want %b", c, lsu_ready, c == 4);
            end
            clock_edge();
        end
        idle_inputs();
        clock_edge();
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!pipe_valid && $urandom_range(0, 3) != 0) begin
                pipe_valid = 1; pipe_rd = 5'($urandom); pipe_data = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) == 0) begin
                lsu_valid = 1; lsu_rd = 5'($urandom); lsu_data = $urandom;
            end
            if (!mdu_valid && $urandom_range(0, 2) == 0) begin
                mdu_valid = 1; mdu_rd = 5'($urandom); mdu_data = $urandom;
            end
            #1;
            g = cur_pick();
            checks++;
            if ({pipe_ready, lsu_ready, mdu_ready} !== onehot(g)) begin
                errors++;
                $display("FAIL rand_ready n%0d got %b want %b", n, {pipe_ready, lsu_ready, mdu_ready}, onehot(g));
            end
            clock_edge();
            checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rand_write n%0d got we=%b x%0d=%h want we=%b x%0d=%h",
                         n, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            checks++;
            if (lsu_starved !== (m_lc == SM) || mdu_starved !== (m_mc == SM)) begin
                errors++;
                $display("FAIL rand_starved n%0d got %b%b want %b%b",
                         n, lsu_starved, mdu_starved, m_lc == SM, m_mc == SM);
            end
            if (g == 0) pipe_valid = 0;
            if (g == 1) lsu_valid = 0;
            if (g == 2) mdu_valid = 0;
        end
        rst_n = 1;
        idle_inputs();
        clock_edge();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        #1;
        test_reset();
        test_single_pipe();
        test_priority();
        test_starvation();
        test_dual_starvation();
        test_rd_zero();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
